// File: rtl/ddr4_user_req_queue_pkg.sv
// Shared types for the DDR4 user request path.
// One queued request is {addr, write, wdata}.
package ddr4_ctrl_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int DATA_WIDTH = 64;
  localparam int RD_CNT_W   = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } ddr4_user_req_t;

endpackage

// File: rtl/ddr4_user_req_queue_if.sv
// System request port, controller user port and response port.
// master = surrounding system/controller, slave = the queue.
interface ddr4_user_req_queue_if
  import ddr4_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic [ADDR_WIDTH-1:0] user_addr;
  logic [DATA_WIDTH-1:0] user_write_data;
  logic                  user_write_en;
  logic                  user_cmd_valid;
  logic                  user_ready;
  logic [DATA_WIDTH-1:0] user_read_data;
  logic                  user_read_data_valid;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [LW-1:0]         level;
  logic [RD_CNT_W-1:0]   rd_outstanding;
  logic                  err_unexpected_rd;

  modport master (
    output req_valid, req_addr, req_write, req_wdata,
    output user_ready, user_read_data, user_read_data_valid,
    input  req_ready, user_addr, user_write_data,
    input  user_write_en, user_cmd_valid,
    input  rsp_valid, rsp_data, level,
    input  rd_outstanding, err_unexpected_rd
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata,
    input  user_ready, user_read_data, user_read_data_valid,
    output req_ready, user_addr, user_write_data,
    output user_write_en, user_cmd_valid,
    output rsp_valid, rsp_data, level,
    output rd_outstanding, err_unexpected_rd
  );

endinterface

// File: rtl/ddr4_user_req_queue_fifo.sv
// Generic show-ahead FIFO; head entry is always on rdata_o.
// Full/empty come from the level counter, pointers wrap freely.
module ddr4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/ddr4_user_req_queue.sv
// In-order request queue in front of the DDR4 user interface,
// with outstanding-read limiting and a registered read response.
module ddr4_user_req_queue
  import ddr4_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int MAX_RD = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  ddr4_user_req_queue_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  ddr4_user_req_t        push_req, head;
  logic                  full, empty;
  logic [LW-1:0]         level;
  logic                  push, pop, cmd_valid;
  logic                  head_rd, at_limit;
  logic                  rd_pop, rd_ret, unexp;
  logic [RD_CNT_W-1:0]   rd_q, rd_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  assign push_req = '{
    addr:  bus.req_addr,
    write: bus.req_write,
    wdata: bus.req_wdata
  };

  ddr4_sync_fifo #(
    .WIDTH ($bits(ddr4_user_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_req),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // A read at the head stalls everything behind it at the limit.
  assign head_rd   = !head.write;
  assign at_limit  = (rd_q == RD_CNT_W'(MAX_RD));
  assign cmd_valid = !empty && !(head_rd && at_limit);
  assign push      = bus.req_valid && !full;
  assign pop       = cmd_valid && bus.user_ready;
  assign rd_pop    = pop && head_rd;
  assign unexp     = bus.user_read_data_valid
                   && (rd_q == '0) && !rd_pop;
  assign rd_ret    = bus.user_read_data_valid && !unexp;

  always_comb begin
    rd_d = rd_q;
    unique case ({rd_pop, rd_ret})
      2'b10:   rd_d = rd_q + 1'b1;
      2'b01:   rd_d = rd_q - 1'b1;
      default: rd_d = rd_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      rsp_valid_q <= rd_ret;
      if (rd_ret) rsp_data_q <= bus.user_read_data;
      if (unexp)  err_q <= 1'b1;
    end
  end

  assign bus.req_ready         = !full;
  assign bus.user_addr         = head.addr;
  assign bus.user_write_data   = head.wdata;
  assign bus.user_write_en     = head.write;
  assign bus.user_cmd_valid    = cmd_valid;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.level             = level;
  assign bus.rd_outstanding    = rd_q;
  assign bus.err_unexpected_rd = err_q;

endmodule

// File: tb/tb_ddr4_user_req_queue.sv
// Directed + random bench for ddr4_user_req_queue.
// Reference model: a queue of requests plus an outstanding-read count.
module tb_ddr4_user_req_queue;
  import ddr4_ctrl_pkg::*;

  localparam int DEPTH  = 8;
  localparam int MAX_RD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ddr4_user_req_queue_if #(.DEPTH(DEPTH)) bus();

  ddr4_user_req_queue #(
    .DEPTH  (DEPTH),
    .MAX_RD (MAX_RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  ddr4_user_req_t q[$];
  int             m_rd = 0;
  bit             m_err = 1'b0;
  bit             m_rsp_v = 1'b0;
  logic [63:0]    m_rsp_d = '0;
  logic [16:0]    fa [8];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.user_read_data_valid = 1'b0;
  endtask

  task automatic put(bit wr, logic [16:0] a, logic [63:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = 0;
    m_err = 1'b0;
    m_rsp_v = 1'b0;
    m_rsp_d = '0;
  endtask

  // Check all outputs mid-cycle, then advance one clock and the model.
  task automatic step();
    bit cv, pop, push, rdpop, rdv, unexp;
    ddr4_user_req_t pr;
    logic [63:0] rdd;
    @(negedge clk);
    cv = (q.size() > 0);
    if (cv && !q[0].write && m_rd == MAX_RD) cv = 1'b0;
    chk("req_ready", 64'(bus.req_ready), 64'(q.size() < DEPTH));
    chk("cmd_valid", 64'(bus.user_cmd_valid), 64'(cv));
    if (cv) begin
      chk("user_addr", 64'(bus.user_addr), 64'(q[0].addr));
      chk("write_en", 64'(bus.user_write_en), 64'(q[0].write));
      if (q[0].write)
        chk("wdata", bus.user_write_data, q[0].wdata);
    end
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("rd_out", 64'(bus.rd_outstanding), 64'(m_rd));
    chk("err", 64'(bus.err_unexpected_rd), 64'(m_err));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_v));
    chk("rsp_data", bus.rsp_data, m_rsp_d);
    pop   = cv && bus.user_ready;
    push  = bus.req_valid && (q.size() < DEPTH);
    rdpop = 1'b0;
    if (pop) rdpop = !q[0].write;
    rdv   = bus.user_read_data_valid;
    unexp = rdv && (m_rd == 0) && !rdpop;
    rdd   = bus.user_read_data;
    pr    = '{addr: bus.req_addr, write: bus.req_write,
              wdata: bus.req_wdata};
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(pr);
    m_rd = m_rd + int'(rdpop) - int'(rdv && !unexp);
    if (unexp) m_err = 1'b1;
    m_rsp_v = rdv && !unexp;
    if (m_rsp_v) m_rsp_d = rdd;
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_cmd_valid"}, 64'(bus.user_cmd_valid), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    chk({tag, "_level"}, 64'(bus.level), 64'd0);
    chk({tag, "_rd_out"}, 64'(bus.rd_outstanding), 64'd0);
    chk({tag, "_err"}, 64'(bus.err_unexpected_rd), 64'd0);
  endtask

  initial begin
    idle();
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.user_ready = 1'b0;
    bus.user_read_data = '0;
    #3;
    chk_reset_vals("por");
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    step();

    // single write
    bus.user_ready = 1'b1;
    put(1'b1, 17'h00123, 64'hDEAD_BEEF_0000_0001);
    step();
    idle();
    chk("single_cv", 64'(bus.user_cmd_valid), 64'd1);
    chk("single_we", 64'(bus.user_write_en), 64'd1);
    chk("single_lvl", 64'(bus.level), 64'd1);
    step();
    chk("single_cv0", 64'(bus.user_cmd_valid), 64'd0);
    chk("single_lvl0", 64'(bus.level), 64'd0);

    // fill with controller stalled, then drain in order
    bus.user_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fa[i] = 17'($urandom);
      put(1'b1, fa[i], {$urandom, $urandom});
      step();
    end
    idle();
    chk("fill_ready", 64'(bus.req_ready), 64'd0);
    chk("fill_lvl", 64'(bus.level), 64'd8);
    bus.user_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fill_order", 64'(bus.user_addr), 64'(fa[i]));
      step();
      if (i == 0)
        chk("fill_ready1", 64'(bus.req_ready), 64'd1);
    end
    chk("fill_empty", 64'(bus.level), 64'd0);

    // read limit
    bus.user_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(1'b0, 17'($urandom), '0);
      step();
    end
    idle();
    bus.user_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("lim_rd", 64'(bus.rd_outstanding), 64'd4);
    chk("lim_cv", 64'(bus.user_cmd_valid), 64'd0);
    chk("lim_lvl", 64'(bus.level), 64'd2);
    bus.user_read_data_valid = 1'b1;
    bus.user_read_data = 64'hA5A5_A5A5_A5A5_A5A5;
    step();
    idle();
    chk("lim_rsp_v", 64'(bus.rsp_valid), 64'd1);
    chk("lim_rsp_d", bus.rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("lim_cv5", 64'(bus.user_cmd_valid), 64'd1);
    step();
    chk("lim_rd5", 64'(bus.rd_outstanding), 64'd4);
    chk("lim_lvl5", 64'(bus.level), 64'd1);

    // drain everything
    for (int i = 0; i < 30; i++) begin
      if (m_rd == 0 && q.size() == 0) break;
      bus.user_read_data_valid = (m_rd > 0);
      bus.user_read_data = {$urandom, $urandom};
      step();
    end
    idle();
    step();

    // read pop coinciding with read return at rd_outstanding == 2
    bus.user_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b0, 17'($urandom), '0);
      step();
    end
    idle();
    bus.user_ready = 1'b1;
    step();
    step();
    chk("sim_rd_pre", 64'(bus.rd_outstanding), 64'd2);
    bus.user_read_data_valid = 1'b1;
    bus.user_read_data = {$urandom, $urandom};
    step();
    idle();
    chk("sim_rd", 64'(bus.rd_outstanding), 64'd2);

    // push coinciding with pop at level 3
    bus.user_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 17'($urandom), {$urandom, $urandom});
      step();
    end
    chk("sim_lvl_pre", 64'(bus.level), 64'd3);
    bus.user_ready = 1'b1;
    step();
    idle();
    chk("sim_lvl", 64'(bus.level), 64'd3);
    for (int i = 0; i < 30; i++) begin
      if (m_rd == 0 && q.size() == 0) break;
      bus.user_read_data_valid = (m_rd > 0);
      bus.user_read_data = {$urandom, $urandom};
      step();
    end
    idle();
    step();

    // unexpected read data
    bus.user_read_data_valid = 1'b1;
    bus.user_read_data = {$urandom, $urandom};
    step();
    idle();
    chk("unexp_err", 64'(bus.err_unexpected_rd), 64'd1);
    chk("unexp_rsp", 64'(bus.rsp_valid), 64'd0);
    step();
    step();
    chk("unexp_sticky", 64'(bus.err_unexpected_rd), 64'd1);

    // mid-operation reset with level 5 and 2 reads outstanding
    bus.user_ready = 1'b1;
    put(1'b0, 17'($urandom), '0);
    step();
    put(1'b0, 17'($urandom), '0);
    step();
    idle();
    step();
    bus.user_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 17'($urandom), {$urandom, $urandom});
      step();
    end
    idle();
    chk("rst_pre_lvl", 64'(bus.level), 64'd5);
    chk("rst_pre_rd", 64'(bus.rd_outstanding), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_ready", 64'(bus.req_ready), 64'd1);
    chk("post_cv", 64'(bus.user_cmd_valid), 64'd0);
    step();
    bus.user_read_data_valid = 1'b1;
    step();
    idle();
    chk("post_unexp", 64'(bus.err_unexpected_rd), 64'd1);
    step();

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.req_valid = 1'($urandom);
      bus.req_write = 1'($urandom);
      bus.req_addr  = 17'($urandom);
      bus.req_wdata = {$urandom, $urandom};
      bus.user_ready = ($urandom_range(0, 3) != 0);
      bus.user_read_data_valid = (m_rd > 0) && ($urandom_range(0, 2) == 0);
      bus.user_read_data = {$urandom, $urandom};
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
